// File: rtl/i2c_scl_timing_gen_pkg.sv
// Shared definitions for the I2C SCL timing generator: mode and phase
// encodings, FSM states and the default quarter-period divisors.
package i2c_pkg;

    // Runtime rate select encodings
    typedef enum logic [1:0] {
        MODE_STD    = 2'b00,
        MODE_FAST   = 2'b01,
        MODE_FMP    = 2'b10,
        MODE_CUSTOM = 2'b11
    } mode_t;

    // Quarter phases of one SCL period: two low quarters then two high quarters
    localparam logic [1:0] PH_LOW0  = 2'd0;
    localparam logic [1:0] PH_LOW1  = 2'd1;
    localparam logic [1:0] PH_HIGH0 = 2'd2;
    localparam logic [1:0] PH_HIGH1 = 2'd3;

    // Generator FSM states
    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Default quarter-period divisors at a 100 MHz system clock
    localparam int DEF_CNT_W    = 16;
    localparam int DEF_DIV_STD  = 250;
    localparam int DEF_DIV_FAST = 63;
    localparam int DEF_DIV_FMP  = 25;

    // Smallest divisor the counter can run with (div-1 must not be zero-wrapped)
    localparam int MIN_DIV = 2;

endpackage

// File: rtl/i2c_quarter_counter.sv
// Quarter-period counter: counts clk cycles up to div-1 and flags the
// terminal count. Can be held (clock stretching) or cleared (idle).
module i2c_quarter_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             hold,
    input  logic [CNT_W-1:0] div,
    output logic             tick
);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] div_m1;

    // Terminal count; a held or cleared counter never completes a quarter
    always_comb begin
        div_m1 = div - CNT_W'(1);
        tick   = !clear && !hold && (cnt == div_m1);
    end

    // Counter register: clear wins, then hold freezes, terminal count wraps to zero
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            cnt <= '0;
        end else if (hold) begin
            cnt <= cnt;
        end else if (tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/i2c_scl_timing_gen.sv
// SCL timing generator: runs a 4-quarter SCL sequence from a quarter-period
// counter, with selectable rate, idle/run control, slave clock stretching in
// the first high quarter and one-cycle SDA change/sample strobes.
module i2c_scl_timing_gen
    import i2c_pkg::*;
#(
    parameter int CNT_W    = DEF_CNT_W,
    parameter int DIV_STD  = DEF_DIV_STD,
    parameter int DIV_FAST = DEF_DIV_FAST,
    parameter int DIV_FMP  = DEF_DIV_FMP
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [CNT_W-1:0] div_custom,
    input  logic             scl_in,
    output logic             scl_out,
    output logic [1:0]       phase,
    output logic             tick,
    output logic             sda_change,
    output logic             sda_sample,
    output logic             stretching,
    output logic             busy
);

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] div_q;
    logic [CNT_W-1:0] div_next;
    logic [CNT_W-1:0] div_sel;
    logic [CNT_W-1:0] div_clamped;
    logic [1:0]       phase_next;
    logic             scl_next;
    logic             tick_next;
    logic             change_next;
    logic             sample_next;
    logic             stretch_next;
    logic             busy_next;
    logic             running;
    logic             hold;
    logic             quarter_done;

    // Pick the divisor for the requested rate and clamp it so a quarter is never shorter than 2 cycles
    always_comb begin
        div_sel = CNT_W'(DIV_STD);
        case (mode_t'(mode))
            MODE_STD:    div_sel = CNT_W'(DIV_STD);
            MODE_FAST:   div_sel = CNT_W'(DIV_FAST);
            MODE_FMP:    div_sel = CNT_W'(DIV_FMP);
            MODE_CUSTOM: div_sel = div_custom;
            default:     div_sel = CNT_W'(DIV_STD);
        endcase
        div_clamped = (div_sel < CNT_W'(MIN_DIV)) ? CNT_W'(MIN_DIV) : div_sel;
    end

    // A slave holding SCL low is only honoured during the first high quarter
    always_comb begin
        running = (state == RUN);
        hold    = running && (phase == PH_HIGH0) && !scl_in;
    end

    i2c_quarter_counter #(
        .CNT_W (CNT_W)
    ) u_quarter_counter (
        .clk   (clk),
        .reset (reset),
        .clear (!running),
        .hold  (hold),
        .div   (div_q),
        .tick  (quarter_done)
    );

    // Next-state and next-output logic: quarter advance, strobes, divisor re-latch and stop at period end
    always_comb begin
        state_next   = state;
        div_next     = div_q;
        phase_next   = phase;
        scl_next     = scl_out;
        tick_next    = 1'b0;
        change_next  = 1'b0;
        sample_next  = 1'b0;
        stretch_next = 1'b0;
        busy_next    = busy;
        case (state)
            IDLE: begin
                phase_next = PH_LOW0;
                scl_next   = 1'b1;
                busy_next  = 1'b0;
                if (en) begin
                    state_next = RUN;
                    div_next   = div_clamped;
                    scl_next   = 1'b0;
                    busy_next  = 1'b1;
                end
            end
            RUN: begin
                stretch_next = hold;
                if (quarter_done) begin
                    tick_next   = 1'b1;
                    change_next = (phase == PH_LOW0);
                    sample_next = (phase == PH_HIGH0);
                    phase_next  = phase + 2'd1;
                    scl_next    = phase_next[1];
                    if (phase == PH_HIGH1) begin
                        if (!en) begin
                            state_next = IDLE;
                            scl_next   = 1'b1;
                            busy_next  = 1'b0;
                        end else begin
                            div_next = div_clamped;
                        end
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State and output registers; reset returns everything to the released, idle bus
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            div_q      <= CNT_W'(DIV_STD);
            phase      <= PH_LOW0;
            scl_out    <= 1'b1;
            tick       <= 1'b0;
            sda_change <= 1'b0;
            sda_sample <= 1'b0;
            stretching <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state      <= state_next;
            div_q      <= div_next;
            phase      <= phase_next;
            scl_out    <= scl_next;
            tick       <= tick_next;
            sda_change <= change_next;
            sda_sample <= sample_next;
            stretching <= stretch_next;
            busy       <= busy_next;
        end
    end

endmodule
